pr_isolating_pipe: RTL and testbench
====================================

PR_ISOLATING_PIPE -- requirements
Module: pr_isolating_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 128: payload width in bits, range 1..1024.
REQ-002 Parameter REG_LENGTH, default 2: number of cascaded stages, range 1..8.
REQ-003 Parameter REG_TYPE, default 2: 1 = forward register (registered valid/data, combinational ready); 2 = skid register (valid, data and ready all registered).
REQ-004 Parameter DRAIN_ON_ISOLATE, default 1: 1 = buffered beats drain to the m side during isolation; 0 = buffered beats are discarded.
REQ-005 Derived constants: CAP = REG_LENGTH*(REG_TYPE==2 ? 2 : 1); OCC_W = $clog2(CAP+1).
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 isolate  in  1  level request to fence the PR boundary.
REQ-009 s_data  in  DATA_WIDTH  upstream payload.
REQ-010 s_valid  in  1  upstream beat valid.
REQ-011 s_ready  out  1  block accepts a beat.
REQ-012 m_data  out  DATA_WIDTH  downstream payload.
REQ-013 m_valid  out  1  downstream beat valid.
REQ-014 m_ready  in  1  downstream accepts a beat.
REQ-015 occupancy  out  OCC_W  number of beats currently buffered.
REQ-016 isolate_done  out  1  isolate is asserted and the block is empty.
REQ-017 flush_count  out  16  beats discarded since reset; saturates at 16'hFFFF.

Function
REQ-018 A beat transfers on s when s_valid && s_ready at a clock edge, and on m when m_valid && m_ready at a clock edge.
REQ-019 Beats leave in acceptance order: no loss, duplication or reordering unless discarded per REQ-027.
REQ-020 Latency: a beat accepted into an empty block at edge T appears on m_valid/m_data in the cycle after edge T+REG_LENGTH-1 (REG_LENGTH cycles).
REQ-021 Throughput: one beat per cycle sustained while m_ready=1, for both REG_TYPE values.
REQ-022 REG_TYPE=1: each stage holds 1 beat; stage ready = stage empty || next stage ready; s_ready may depend combinationally on m_ready.
REQ-023 REG_TYPE=2: each stage holds a main and a skid entry; stage ready = registered skid-empty flag; no combinational path from m_ready to s_ready.
REQ-024 While m_valid=1 and m_ready=0, m_data is held stable.
REQ-025 occupancy += 1 on an s transfer, -= 1 on an m transfer; unchanged when both occur in the same cycle; never exceeds CAP; s_ready=0 whenever occupancy=CAP.
REQ-026 Isolation: while isolate=1, s_ready=0 regardless of s_valid.
REQ-027 DRAIN_ON_ISOLATE=1: buffered beats continue to drain normally. DRAIN_ON_ISOLATE=0: on the first edge with isolate=1, all stages clear, occupancy becomes 0, flush_count increases by the prior occupancy (saturating), m_valid is 0 from the next cycle, and m_valid is forced to 0 while isolate=1.
REQ-028 isolate_done = isolate && (occupancy==0), registered (one-cycle delay from the condition).
REQ-029 Deasserting isolate restores normal acceptance on the next cycle; isolate_done falls in the cycle after isolate falls.
REQ-030 An s beat offered in the same cycle isolate rises is not accepted.

Reset
REQ-031 rst=1 at an edge: all stages empty; m_valid=0; occupancy=0; isolate_done=0; flush_count=0.
REQ-032 During rst: s_ready=0. REG_TYPE=1: s_ready=1 the cycle after rst falls. REG_TYPE=2: s_ready=1 one cycle later still (registered).
REQ-033 rst mid-stream discards buffered beats without incrementing flush_count; rst overrides isolate.

Verification
REQ-034 REG_TYPE=2, REG_LENGTH=2: stream 100 incrementing beats, m_ready toggled randomly at 50% -> 100 beats out in order, s_ready never combinationally dependent on m_ready, occupancy<=4.
REQ-035 REG_TYPE=1, REG_LENGTH=3, m_ready=1: single beat 0xA5 accepted at edge T -> m_valid=1 with m_data=0xA5 after edge T+2; back-to-back beats emerge at 1 per cycle.
REQ-036 m_ready=0, fill until s_ready=0 -> occupancy=CAP (4 for REG_TYPE=2, REG_LENGTH=2); release m_ready -> all beats drain in order.
REQ-037 DRAIN_ON_ISOLATE=0 with 3 beats buffered, assert isolate -> s_ready=0, m_valid=0 next cycle, occupancy=0, flush_count=3, isolate_done=1 one cycle later.
REQ-038 DRAIN_ON_ISOLATE=1 with 3 beats buffered, assert isolate, m_ready=1 -> 3 beats delivered, then isolate_done=1; deassert isolate -> s_ready=1 next cycle.
REQ-039 Assert rst with 2 beats buffered -> occupancy=0, m_valid=0, flush_count unchanged at 0.

Source files
------------

// File: rtl/pr_isolating_pipe.sv
// rtl/pr_isolating_pipe.sv - cascaded register slice that can be fenced for partial reconfiguration
// Stages are forward registers (REG_TYPE=1) or skid registers (REG_TYPE=2).
module pr_isolating_pipe #(
   parameter int DATA_WIDTH       = 128,
   parameter int REG_LENGTH       = 2,
   parameter int REG_TYPE         = 2,
   parameter int DRAIN_ON_ISOLATE = 1,
   localparam int CAP             = REG_LENGTH * ((REG_TYPE == 2) ? 2 : 1),
   localparam int OCC_W           = $clog2(CAP + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  isolate,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OCC_W-1:0]      occupancy,
   output logic                  isolate_done,
   output logic [15:0]           flush_count
);

   logic        kill;
   logic        armed;
   logic        s_fire;
   logic        m_fire;
   logic [16:0] flush_sum;

   // Discard mode clears every stage on each isolated edge and hides m_valid meanwhile.
   assign kill = (DRAIN_ON_ISOLATE == 0) && isolate;

   // Skid stages publish a registered ready, so acceptance starts one cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   genvar i;
   generate
      for (i = 0; i < REG_LENGTH; i++) begin : g_stage
         logic                  in_v;
         logic [DATA_WIDTH-1:0] in_d;
         logic                  rdy;
         logic                  out_rdy;
         logic                  take;
         logic                  main_v;
         logic [DATA_WIDTH-1:0] main_d;

         if (i == 0) begin : g_head
            assign in_v = s_fire;
            assign in_d = s_data;
         end else begin : g_link
            assign in_v = g_stage[i-1].main_v;
            assign in_d = g_stage[i-1].main_d;
         end

         if (i == REG_LENGTH - 1) begin : g_tail
            assign out_rdy = m_ready && !kill;
         end else begin : g_mid
            assign out_rdy = g_stage[i+1].rdy;
         end

         assign take = in_v && rdy;

         if (REG_TYPE == 2) begin : g_skid
            logic                  skid_v;
            logic [DATA_WIDTH-1:0] skid_d;

            assign rdy = !skid_v;

            always_ff @(posedge clk) begin
               if (rst || kill) begin
                  main_v <= 1'b0;
                  skid_v <= 1'b0;
               end else if (out_rdy || !main_v) begin
                  // Skid entry has priority so beat order is preserved.
                  if (skid_v) begin
                     main_v <= 1'b1;
                     main_d <= skid_d;
                     skid_v <= 1'b0;
                  end else begin
                     main_v <= take;
                     if (take) begin
                        main_d <= in_d;
                     end
                  end
               end else if (take) begin
                  skid_v <= 1'b1;
                  skid_d <= in_d;
               end
            end
         end else begin : g_fwd
            assign rdy = !main_v || out_rdy;

            always_ff @(posedge clk) begin
               if (rst || kill) begin
                  main_v <= 1'b0;
               end else if (rdy) begin
                  main_v <= in_v;
                  if (in_v) begin
                     main_d <= in_d;
                  end
               end
            end
         end
      end
   endgenerate

   assign s_ready = g_stage[0].rdy && !isolate && !rst && ((REG_TYPE == 1) || armed);
   assign s_fire  = s_valid && s_ready;
   assign m_valid = g_stage[REG_LENGTH-1].main_v && !kill;
   assign m_data  = g_stage[REG_LENGTH-1].main_d;
   assign m_fire  = m_valid && m_ready;

   assign flush_sum = {1'b0, flush_count} + 17'(occupancy);

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy    <= '0;
         flush_count  <= '0;
         isolate_done <= 1'b0;
      end else begin
         isolate_done <= isolate && (occupancy == '0);
         if (kill) begin
            occupancy   <= '0;
            flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
         end else if (s_fire && !m_fire) begin
            occupancy <= occupancy + OCC_W'(1);
         end else if (!s_fire && m_fire) begin
            occupancy <= occupancy - OCC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pr_isolating_pipe.sv
// tb/tb_pr_isolating_pipe.sv - scoreboard bench over three pr_isolating_pipe configurations
// a: skid x2 drain, b: forward x3 drain, c: skid x2 discard.
module tb_pr_isolating_pipe;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic          a_iso, a_sv, a_sr, a_mv, a_mr, a_done;
   logic [DW-1:0] a_sd, a_md;
   logic [2:0]    a_occ;
   logic [15:0]   a_fc;

   logic          b_iso, b_sv, b_sr, b_mv, b_mr, b_done;
   logic [DW-1:0] b_sd, b_md;
   logic [1:0]    b_occ;
   logic [15:0]   b_fc;

   logic          c_iso, c_sv, c_sr, c_mv, c_mr, c_done;
   logic [DW-1:0] c_sd, c_md;
   logic [2:0]    c_occ;
   logic [15:0]   c_fc;

   pr_isolating_pipe #(.DATA_WIDTH(DW), .REG_LENGTH(2), .REG_TYPE(2), .DRAIN_ON_ISOLATE(1)) dut_a (
      .clk(clk), .rst(rst), .isolate(a_iso), .s_data(a_sd), .s_valid(a_sv), .s_ready(a_sr),
      .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr), .occupancy(a_occ),
      .isolate_done(a_done), .flush_count(a_fc));

   pr_isolating_pipe #(.DATA_WIDTH(DW), .REG_LENGTH(3), .REG_TYPE(1), .DRAIN_ON_ISOLATE(1)) dut_b (
      .clk(clk), .rst(rst), .isolate(b_iso), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
      .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr), .occupancy(b_occ),
      .isolate_done(b_done), .flush_count(b_fc));

   pr_isolating_pipe #(.DATA_WIDTH(DW), .REG_LENGTH(2), .REG_TYPE(2), .DRAIN_ON_ISOLATE(0)) dut_c (
      .clk(clk), .rst(rst), .isolate(c_iso), .s_data(c_sd), .s_valid(c_sv), .s_ready(c_sr),
      .m_data(c_md), .m_valid(c_mv), .m_ready(c_mr), .occupancy(c_occ),
      .isolate_done(c_done), .flush_count(c_fc));

   int checks = 0;
   int errors = 0;
   int a_out  = 0;
   int b_out  = 0;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted beats are pushed, delivered beats are popped and compared.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_mv && a_mr) begin
            a_out++;
            check("a_sb_nonempty", 64'(qa.size() != 0), 64'(1));
            if (qa.size() != 0) check("a_order", 64'(a_md), 64'(qa.pop_front()));
         end
         if (a_sv && a_sr) qa.push_back(a_sd);
         if (b_mv && b_mr) begin
            b_out++;
            check("b_sb_nonempty", 64'(qb.size() != 0), 64'(1));
            if (qb.size() != 0) check("b_order", 64'(b_md), 64'(qb.pop_front()));
         end
         if (b_sv && b_sr) qb.push_back(b_sd);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n0;
      int k;
      int t;
      logic sr0;
      logic acc;

      rst = 1'b1;
      {a_iso, a_sv, a_mr, b_iso, b_sv, b_mr, c_iso, c_sv, c_mr} = '0;
      a_sd = '0; b_sd = '0; c_sd = '0;
      repeat (3) tick();

      check("rst_a_sready", 64'(a_sr), 64'(0));
      check("rst_b_sready", 64'(b_sr), 64'(0));
      check("rst_c_sready", 64'(c_sr), 64'(0));
      check("rst_a_mvalid", 64'(a_mv), 64'(0));
      check("rst_a_occ", 64'(a_occ), 64'(0));
      check("rst_a_done", 64'(a_done), 64'(0));
      check("rst_a_flush", 64'(a_fc), 64'(0));
      check("rst_b_mvalid", 64'(b_mv), 64'(0));
      check("rst_c_occ", 64'(c_occ), 64'(0));

      rst = 1'b0;
      #1;
      check("b_sready_after_rst", 64'(b_sr), 64'(1));
      check("a_sready_held_after_rst", 64'(a_sr), 64'(0));
      tick();
      check("a_sready_armed", 64'(a_sr), 64'(1));

      // forward x3 latency
      b_mr = 1'b1; b_sd = 16'h00A5; b_sv = 1'b1;
      tick();
      b_sv = 1'b0;
      check("b_lat_t", 64'(b_mv), 64'(0));
      tick();
      check("b_lat_t1", 64'(b_mv), 64'(0));
      tick();
      check("b_lat_t2_valid", 64'(b_mv), 64'(1));
      check("b_lat_t2_data", 64'(b_md), 64'(16'h00A5));
      tick();
      check("b_lat_gone", 64'(b_mv), 64'(0));

      // forward x3 back-to-back throughput
      n0 = b_out;
      for (int i = 0; i < 6; i++) begin
         b_sd = 16'(16'h10 + i); b_sv = 1'b1;
         check("b_burst_ready", 64'(b_sr), 64'(1));
         tick();
      end
      b_sv = 1'b0;
      repeat (4) tick();
      check("b_burst_count", 64'(b_out - n0), 64'(6));

      // skid x2 fill to capacity then drain
      a_mr = 1'b0; n = 0;
      while (a_sr && n < 10) begin
         a_sv = 1'b1; a_sd = 16'(16'h100 + n);
         tick();
         n++;
      end
      a_sv = 1'b0;
      check("a_fill_count", 64'(n), 64'(4));
      check("a_fill_occ", 64'(a_occ), 64'(4));
      check("a_fill_sready", 64'(a_sr), 64'(0));
      check("a_fill_mvalid", 64'(a_mv), 64'(1));
      a_mr = 1'b1;
      for (t = 0; t < 20 && qa.size() != 0; t++) tick();
      check("a_fill_drained", 64'(qa.size()), 64'(0));
      check("a_fill_occ_zero", 64'(a_occ), 64'(0));

      // skid x2 random backpressure stream
      k = 0; t = 0; n0 = a_out;
      while (k < 100 && t < 2000) begin
         a_sv = 1'b1; a_sd = 16'(k);
         a_mr = 1'($urandom_range(0, 1));
         #1;
         sr0 = a_sr;
         a_mr = !a_mr;
         #1;
         check("a_sready_comb", 64'(a_sr), 64'(sr0));
         a_mr = !a_mr;
         #1;
         check("a_occ_bound", 64'(a_occ <= 3'd4), 64'(1));
         acc = a_sr;
         tick();
         if (acc) k++;
         t++;
      end
      a_sv = 1'b0; a_mr = 1'b1;
      check("a_stream_accepted", 64'(k), 64'(100));
      for (t = 0; t < 50 && (a_out - n0) < 100; t++) tick();
      check("a_stream_delivered", 64'(a_out - n0), 64'(100));
      check("a_stream_sb_empty", 64'(qa.size()), 64'(0));

      // drain-on-isolate
      a_mr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_sv = 1'b1; a_sd = 16'(16'h200 + i);
         tick();
      end
      a_sv = 1'b0;
      check("a_iso_occ3", 64'(a_occ), 64'(3));
      a_iso = 1'b1; a_sv = 1'b1; a_sd = 16'hDEAD;
      #1;
      check("a_iso_sready", 64'(a_sr), 64'(0));
      n0 = a_out; a_mr = 1'b1;
      for (t = 0; t < 20 && !a_done; t++) tick();
      check("a_iso_done", 64'(a_done), 64'(1));
      check("a_iso_delivered", 64'(a_out - n0), 64'(3));
      check("a_iso_occ0", 64'(a_occ), 64'(0));
      a_sv = 1'b0; a_iso = 1'b0;
      tick();
      check("a_deiso_sready", 64'(a_sr), 64'(1));
      check("a_deiso_done", 64'(a_done), 64'(0));

      // discard-on-isolate
      for (int i = 0; i < 3; i++) begin
         c_sv = 1'b1; c_sd = 16'(16'h300 + i);
         tick();
      end
      c_sv = 1'b0;
      check("c_occ3", 64'(c_occ), 64'(3));
      check("c_mvalid_before", 64'(c_mv), 64'(1));
      c_iso = 1'b1; c_sv = 1'b1; c_sd = 16'hBEEF;
      #1;
      check("c_iso_sready", 64'(c_sr), 64'(0));
      tick();
      check("c_iso_mvalid", 64'(c_mv), 64'(0));
      check("c_iso_occ", 64'(c_occ), 64'(0));
      check("c_iso_flush", 64'(c_fc), 64'(3));
      check("c_iso_done_early", 64'(c_done), 64'(0));
      tick();
      check("c_iso_done", 64'(c_done), 64'(1));
      check("c_iso_flush_hold", 64'(c_fc), 64'(3));
      check("c_iso_occ_hold", 64'(c_occ), 64'(0));
      c_sv = 1'b0; c_iso = 1'b0;
      tick();
      check("c_deiso_sready", 64'(c_sr), 64'(1));
      check("c_deiso_done", 64'(c_done), 64'(0));

      // reset mid-stream
      b_mr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         b_sv = 1'b1; b_sd = 16'(16'h400 + i);
         tick();
      end
      b_sv = 1'b0;
      check("b_rst_occ2", 64'(b_occ), 64'(2));
      rst = 1'b1;
      tick();
      check("b_rst_occ", 64'(b_occ), 64'(0));
      check("b_rst_mvalid", 64'(b_mv), 64'(0));
      check("b_rst_flush", 64'(b_fc), 64'(0));
      qb.delete();
      rst = 1'b0;
      tick();
      check("b_post_rst_sready", 64'(b_sr), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
